// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO, owning HI/LO; fixed Width+1 cycle latency.
// No queueing: start_i is ignored while busy_o=1; MTHI/MTLO complete in one edge from IDLE.
module mul_div_unit #(
  parameter int Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Width-1:0] hi_o,
  output logic [Width-1:0] lo_o
);

  localparam int CW = $clog2(Width);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               div_zero;
  logic [Width-1:0]   a_raw;
  logic [Width-1:0]   mcand;
  logic [2*Width-1:0] acc;

  logic               accept_arith;
  logic               op_signed;
  logic               a_neg;
  logic               b_neg;
  logic [Width-1:0]   a_mag;
  logic [Width-1:0]   b_mag;

  assign accept_arith = start_i && (state == S_IDLE) && !op_i[2];
  assign op_signed    = !op_i[0];
  assign a_neg        = op_signed && a_i[Width-1];
  assign b_neg        = op_signed && b_i[Width-1];
  assign a_mag        = a_neg ? -a_i : a_i;
  assign b_mag        = b_neg ? -b_i : b_i;

  // acc holds {partial product, remaining multiplier} for multiply and
  // {partial remainder, dividend/quotient bits} for divide.
  logic [Width:0]     mul_sum;
  logic [Width:0]     div_trial;
  logic [2*Width-1:0] acc_step;

  assign mul_sum   = {1'b0, acc[2*Width-1:Width]} + (acc[0] ? {1'b0, mcand} : '0);
  assign div_trial = {acc[2*Width-1:Width], acc[Width-1]} - {1'b0, mcand};

  always_comb begin
    acc_step = {mul_sum, acc[Width-1:1]};
    if (is_div) begin
      if (div_trial[Width]) begin
        acc_step = {acc[2*Width-2:0], 1'b0};
      end else begin
        acc_step = {div_trial[Width-1:0], acc[Width-2:0], 1'b1};
      end
    end
  end

  logic [2*Width-1:0] mul_res;
  logic [Width-1:0]   quo_res;
  logic [Width-1:0]   rem_res;

  assign mul_res = neg_q ? -acc : acc;
  assign quo_res = neg_q ? -acc[Width-1:0] : acc[Width-1:0];
  assign rem_res = neg_r ? -acc[2*Width-1:Width] : acc[2*Width-1:Width];

  assign busy_o = (state != S_IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= S_IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      a_raw    <= '0;
      mcand    <= '0;
      acc      <= '0;
      done_o   <= 1'b0;
      hi_o     <= '0;
      lo_o     <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept_arith) begin
            state    <= S_CALC;
            cnt      <= CW'(Width - 1);
            is_div   <= op_i[1];
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= op_i[1] && (b_i == '0);
            a_raw    <= a_i;
            if (op_i[1]) begin
              mcand <= b_mag;
              acc   <= {{Width{1'b0}}, a_mag};
            end else begin
              mcand <= a_mag;
              acc   <= {{Width{1'b0}}, b_mag};
            end
          end else if (start_i && op_i == 3'b100) begin
            hi_o <= a_i;
          end else if (start_i && op_i == 3'b101) begin
            lo_o <= a_i;
          end
        end
        S_CALC: begin
          acc <= acc_step;
          if (cnt == '0) begin
            state <= S_FIN;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_FIN: begin
          state  <= S_IDLE;
          done_o <= 1'b1;
          if (!is_div) begin
            hi_o <= mul_res[2*Width-1:Width];
            lo_o <= mul_res[Width-1:0];
          end else if (div_zero) begin
            hi_o <= a_raw;
            lo_o <= '1;
          end else begin
            hi_o <= rem_res;
            lo_o <= quo_res;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomised + directed bench for mul_div_unit: expected {hi,lo} pushed at issue, popped on done_o.
module tb_mul_div_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  mul_div_unit #(.Width(32)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .start_i(start_i),
    .op_i   (op_i),
    .a_i    (a_i),
    .b_i    (b_i),
    .busy_o (busy_o),
    .done_o (done_o),
    .hi_o   (hi_o),
    .lo_o   (lo_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int push_cnt = 0;

  logic [63:0] exp_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic on the architectural rules.
  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    logic [31:0] uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (op)
      3'd0: begin
        p = 64'(sa * sb);
      end
      3'd1: begin
        p = {32'b0, a} * {32'b0, b};
      end
      3'd2: begin
        if (b == 32'd0) begin
          p = {a, 32'hFFFF_FFFF};
        end else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) begin
          p = {a, 32'hFFFF_FFFF};
        end else begin
          uq = a / b;
          ur = a % b;
          p = {ur, uq};
        end
      end
    endcase
    return p;
  endfunction

  // Monitor: pops one expectation per done pulse and flags stray or stretched pulses.
  logic prev_done = 1'b0;
  always @(negedge clk_i) begin
    logic [63:0] e;
    if (rst_ni === 1'b1 && done_o === 1'b1) begin
      done_cnt++;
      check("done_width", {63'b0, prev_done}, 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got hi=%h lo=%h with no pending op", hi_o, lo_o);
      end else begin
        e = exp_q.pop_front();
        check("result", {hi_o, lo_o}, e);
      end
    end
    prev_done = (rst_ni === 1'b1) ? done_o : 1'b0;
  end

  task automatic run_arith(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input bit inject);
    logic [63:0] e;
    int cycles;
    bit hold_ok;
    e = ref_model(op, a, b);
    exp_q.push_back(e);
    push_cnt++;
    @(negedge clk_i);
    start_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    cycles  = 0;
    hold_ok = 1'b1;
    while (busy_o && cycles < 100) begin
      if (hi_o !== m_hi || lo_o !== m_lo) hold_ok = 1'b0;
      if (inject && cycles == 10) begin
        start_i = 1'b1;
        op_i    = 3'd3;
        a_i     = $urandom;
        b_i     = $urandom;
      end else begin
        start_i = 1'b0;
      end
      @(posedge clk_i);
      #1;
      cycles++;
    end
    start_i = 1'b0;
    check("busy_cycles", 64'(cycles), 64'd33);
    check("hold_during_busy", {63'b0, hold_ok}, 64'd1);
    m_hi = e[63:32];
    m_lo = e[31:0];
  endtask

  task automatic run_mt(input logic [2:0] op, input logic [31:0] a);
    start_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = $urandom;
    @(posedge clk_i);
    #1;
    if (op == 3'b100) m_hi = a;
    else if (op == 3'b101) m_lo = a;
    check("mt_hilo", {hi_o, lo_o}, {m_hi, m_lo});
    check("mt_busy_done", {62'b0, busy_o, done_o}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int k;
    rst_ni  = 1'b0;
    start_i = 1'b0;
    op_i    = 3'd0;
    a_i     = '0;
    b_i     = '0;
    #1;
    check("reset_state", {30'b0, busy_o, done_o, hi_o, lo_o}, 64'd0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Directed cases; consecutive calls also exercise done_o and start_i coinciding.
    run_arith(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_arith(3'd0, 32'hFFFF_FFFD, 32'd7, 1'b0);
    run_arith(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_arith(3'd3, 32'd7, 32'd2, 1'b0);
    run_arith(3'd2, 32'h1234_5678, 32'd0, 1'b0);
    run_arith(3'd3, 32'h1234_5678, 32'd0, 1'b0);
    run_arith(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_arith(3'd2, 32'd7, 32'hFFFF_FFFE, 1'b0);

    // MTHI then MTLO on consecutive cycles, then the reserved no-op encodings.
    @(negedge clk_i);
    run_mt(3'b100, 32'hA5A5_A5A5);
    run_mt(3'b101, 32'h5A5A_5A5A);
    run_mt(3'b110, 32'hDEAD_BEEF);
    run_mt(3'b111, 32'hCAFE_F00D);
    start_i = 1'b0;

    // Request while busy must be dropped.
    run_arith(3'd0, 32'h0001_2345, 32'hFFFF_0001, 1'b1);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      k   = $urandom_range(0, 9);
      if (k == 0) rb = 32'd0;
      else if (k == 1) rb = 32'hFFFF_FFFF;
      else if (k == 2) ra = 32'h8000_0000;
      else if (k == 3) rb = rb >> $urandom_range(8, 31);
      run_arith(rop, ra, rb, 1'b0);
    end

    // Reset mid-CALC aborts asynchronously and yields no done_o afterwards.
    @(negedge clk_i);
    start_i = 1'b1;
    op_i    = 3'd1;
    a_i     = 32'h1357_9BDF;
    b_i     = 32'h2468_ACE0;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_reset", {30'b0, busy_o, done_o, hi_o, lo_o}, 64'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (40) @(posedge clk_i);
    #1;
    check("post_reset_idle", {30'b0, busy_o, done_o, hi_o, lo_o}, 64'd0);

    repeat (3) @(posedge clk_i);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("done_count", 64'(done_cnt), 64'(push_cnt));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
